// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Combinational lookup on the Fetch PC; table updates from resolved branches in Decode.
module btb_predictor #(
    parameter int ENTRIES = 64,
    parameter int PC_W    = 32,
    parameter int TAG_W   = 12,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Branch,
    input  logic [PC_W-1:0]  PC,
    input  logic             UpdateEnable,
    input  logic             BranchTaken,
    input  logic [PC_W-1:0]  PCUpdate,
    input  logic [PC_W-1:0]  PCBranch,
    input  logic             Invalidate,
    output logic [PC_W-1:0]  PredictedTarget,
    output logic             Prediction,
    output logic             Hit,
    output logic [CNT_W-1:0] MispredictCount
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [PC_W-1:0]    target_mem [ENTRIES];
    logic [CTR_W-1:0]   ctr_mem    [ENTRIES];

    logic [IDX_W-1:0] lookup_idx;
    logic [TAG_W-1:0] lookup_tag;
    logic [IDX_W-1:0] update_idx;
    logic [TAG_W-1:0] update_tag;
    logic             lookup_hit;
    logic             update_hit;
    logic [CTR_W-1:0] update_ctr;
    logic             mispredict;
    logic             allocate;
    logic             unused_pc_bits;

    assign lookup_idx = PC[IDX_W+1:2];
    assign lookup_tag = PC[IDX_W+TAG_W+1:IDX_W+2];
    assign update_idx = PCUpdate[IDX_W+1:2];
    assign update_tag = PCUpdate[IDX_W+TAG_W+1:IDX_W+2];

    // Only the index and tag fields of the PCs take part in lookup and update.
    assign unused_pc_bits = ^{PC, PCUpdate};

    assign lookup_hit      = valid[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
    assign Hit             = lookup_hit;
    assign Prediction      = Branch && lookup_hit && ctr_mem[lookup_idx][CTR_W-1];
    assign PredictedTarget = lookup_hit ? target_mem[lookup_idx] : '0;

    assign update_hit = valid[update_idx] && (tag_mem[update_idx] == update_tag);
    assign update_ctr = ctr_mem[update_idx];
    assign mispredict = (update_hit && update_ctr[CTR_W-1]) != BranchTaken;
    assign allocate   = UpdateEnable && !update_hit && BranchTaken;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if (Invalidate) begin
            valid <= '0;
        end else if (allocate) begin
            valid[update_idx] <= 1'b1;
        end
    end

    // Payload storage is unreset; an edge taken while reset is low must not write it.
    always_ff @(posedge clk) begin
        if (reset && UpdateEnable && !Invalidate) begin
            if (update_hit) begin
                if (BranchTaken) begin
                    target_mem[update_idx] <= PCBranch;
                    if (update_ctr != CTR_MAX) begin
                        ctr_mem[update_idx] <= update_ctr + CTR_W'(1);
                    end
                end else if (update_ctr != '0) begin
                    ctr_mem[update_idx] <= update_ctr - CTR_W'(1);
                end
            end else if (BranchTaken) begin
                tag_mem[update_idx]    <= update_tag;
                target_mem[update_idx] <= PCBranch;
                ctr_mem[update_idx]    <= CTR_INIT;
            end
        end
    end

    // Counts mispredicts even for updates dropped by a concurrent Invalidate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            MispredictCount <= '0;
        end else if (UpdateEnable && mispredict && MispredictCount != CNT_MAX) begin
            MispredictCount <= MispredictCount + CNT_W'(1);
        end
    end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Parametrised direct-mapped branch target buffer with per-entry saturating direction counters.
- Sits in Fetch: looks up PCF combinationally and supplies the predicted target and taken prediction to the PC-select mux.
- Updated from Decode on every resolved branch, not only on a mispredict.
- Adds tag checking, configurable counter width, bulk invalidate and a mispredict performance counter.

Parameters:
- ENTRIES, 64, number of table entries; power of two, 4..1024.
- PC_W, 32, PC and target width.
- TAG_W, 12, stored tag bits; TAG_W + log2(ENTRIES) + 2 <= PC_W.
- CTR_W, 2, direction counter width, 1..4.
- CNT_W, 16, width of the mispredict counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- Branch  in  1  Fetch instruction is a branch; qualifies the prediction.
- PC  in  PC_W  Fetch PC, lookup address.
- UpdateEnable  in  1  resolved branch in Decode; update this cycle.
- BranchTaken  in  1  resolved direction.
- PCUpdate  in  PC_W  PC of the resolved branch.
- PCBranch  in  PC_W  resolved target.
- Invalidate  in  1  synchronous clear of all valid bits.
- PredictedTarget  out  PC_W  target of the hit entry, 0 when no hit.
- Prediction  out  1  predict taken.
- Hit  out  1  valid entry with matching tag for PC.
- MispredictCount  out  CNT_W  saturating count of mispredicted updates.

Behaviour:
- Indexing and tags:
  - IDX_W = log2(ENTRIES).
  - index = PC[IDX_W+1:2]; tag = PC[IDX_W+TAG_W+1:IDX_W+2].
  - The same fields are taken from PCUpdate for updates.
- Entry contents: valid, tag[TAG_W], target[PC_W], ctr[CTR_W].
- Lookup (combinational, zero latency):
  - Hit = valid[index] & tag match.
  - Prediction = Branch & Hit & ctr MSB.
  - PredictedTarget = Hit ? target : 0.
  - Lookup is independent of Branch except for Prediction.
- Update, on the rising edge when UpdateEnable=1; uhit = update-side hit at PCUpdate:
  - uhit & BranchTaken: ctr = min(ctr+1, 2^CTR_W-1); target = PCBranch.
  - uhit & ~BranchTaken: ctr = max(ctr-1, 0). Target and valid are kept; the entry is not deallocated at 0.
  - ~uhit & BranchTaken: allocate, overwriting any entry at that index. valid=1, tag and target written, ctr = 2^(CTR_W-1) (weakly taken).
  - ~uhit & ~BranchTaken: no table change.
- Mispredict detection and counting:
  - An update is a mispredict when (uhit & ctr MSB) != BranchTaken, using the counter value before the update.
  - On each mispredicted update, MispredictCount increments and saturates at 2^CNT_W-1.
- Lookup and update to the same index in the same cycle:
  - Lookup returns the pre-edge contents; there is no bypass.
  - The new state is visible the cycle after the edge.
- Invalidate:
  - Clears every valid bit on the edge; ctr, tag and target are left stale.
  - Invalidate has priority over an update in the same cycle; that update is discarded.
  - The mispredict counter still counts that update.
- Reset (reset=0, asynchronous):
  - All valid bits and MispredictCount clear to 0.
  - As a result, Hit=0, Prediction=0 and PredictedTarget=0 during and after reset.
  - Tag, target and ctr storage needs no reset.
  - Reset asserted mid-operation discards any update in flight.
- Reset release: must be tolerated asynchronously; the first update is accepted on the first clock edge with reset=1.
- CTR_W=1 degenerates to a last-outcome predictor: allocate with ctr=1.

Test Plan:
- Reset then lookup. Stimulus: ENTRIES=16, reset=0 then 1; PC=0x100, Branch=1. Response: Hit=0, Prediction=0, PredictedTarget=0, MispredictCount=0.
- Allocate on taken. Stimulus: update PCUpdate=0x100, PCBranch=0x200, BranchTaken=1; next cycle PC=0x100, Branch=1. Response: Hit=1, Prediction=1, PredictedTarget=0x200, MispredictCount=1.
- Counter hysteresis. Stimulus: from the previous state, two not-taken updates at 0x100. Response:
  - After the first update: ctr=01, Prediction=0, Hit=1, MispredictCount=2.
  - After the second update: ctr=00, MispredictCount=2, entry still valid.
- Tag conflict. Stimulus: entry at 0x100 valid; update PCUpdate=0x140 (same index, different tag), taken, PCBranch=0x300. Response: lookup 0x100 gives Hit=0; lookup 0x140 gives Hit=1, target 0x300.
- Same-cycle lookup and update. Stimulus: PC=0x100 while the allocating update at 0x100 is on the same edge. Response: Hit=0 that cycle, Hit=1 the next cycle.
- Invalidate priority and count saturation. Stimulus:
  - Assert Invalidate with a taken update at 0x180. Response: all lookups miss afterwards.
  - CNT_W=2, five mispredicts. Response: MispredictCount=3.
- Async reset mid-run. Stimulus: pull reset low between edges. Response: Hit and MispredictCount go to 0 immediately, with no clock edge required.
